// File: rtl/branch_resolve_bht_pkg.sv
// Shared types for the EX branch resolver and its bimodal history table.
// Compare-mode encoding, counter type and counter update helper.
package branch_resolve_bht_pkg;

  typedef logic [3:0] br_op_t;

  localparam br_op_t BR_BEQ    = 4'd0;
  localparam br_op_t BR_BNE    = 4'd1;
  localparam br_op_t BR_BGEZ   = 4'd2;
  localparam br_op_t BR_BGTZ   = 4'd3;
  localparam br_op_t BR_BLEZ   = 4'd4;
  localparam br_op_t BR_BLTZ   = 4'd5;
  localparam br_op_t BR_BLT    = 4'd6;
  localparam br_op_t BR_BGE    = 4'd7;
  localparam br_op_t BR_BLTU   = 4'd8;
  localparam br_op_t BR_BGEU   = 4'd9;
  localparam br_op_t BR_ALWAYS = 4'd10;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT = 2'b00;
  localparam cnt_t CNT_WNT = 2'b01;
  localparam cnt_t CNT_ST  = 2'b11;

  function automatic cnt_t cnt_next(
    input cnt_t c,
    input logic taken
  );
    cnt_t n;
    n = c;
    if (taken) begin
      if (c != CNT_ST)
        n = c + 2'd1;
    end else begin
      if (c != CNT_SNT)
        n = c - 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_resolve_bht_if.sv
// Bundle between the pipeline (fetch lookup + EX branch)
// and the branch resolver / history table.
interface branch_resolve_bht_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);

  logic [PC_W-1:0] predPc;
  logic            predTaken;

  logic            exValid;
  logic [3:0]      exOp;
  logic [XLEN-1:0] exDin1;
  logic [XLEN-1:0] exDin2;
  logic [PC_W-1:0] exPc;
  logic [PC_W-1:0] exTarget;
  logic            exPredTaken;
  logic            stall;
  logic            flush;

  logic            resValid;
  logic            resTaken;
  logic            mispredict;
  logic [PC_W-1:0] redirectPc;
  logic            illegalOp;

  modport master (
    output predPc,
    output exValid,
    output exOp,
    output exDin1,
    output exDin2,
    output exPc,
    output exTarget,
    output exPredTaken,
    output stall,
    output flush,
    input  predTaken,
    input  resValid,
    input  resTaken,
    input  mispredict,
    input  redirectPc,
    input  illegalOp
  );

  modport slave (
    input  predPc,
    input  exValid,
    input  exOp,
    input  exDin1,
    input  exDin2,
    input  exPc,
    input  exTarget,
    input  exPredTaken,
    input  stall,
    input  flush,
    output predTaken,
    output resValid,
    output resTaken,
    output mispredict,
    output redirectPc,
    output illegalOp
  );

endinterface

// File: rtl/branch_resolve_bht_cond.sv
// Combinational branch condition evaluator.
// Flags unencoded compare modes as illegal (cond forced low).
module branch_cond
  import branch_resolve_bht_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  br_op_t          op,
  input  logic [XLEN-1:0] din1,
  input  logic [XLEN-1:0] din2,
  output logic            cond,
  output logic            illegal
);

  logic neg1;
  logic zero1;
  logic slt;
  logic ult;

  assign neg1  = din1[XLEN-1];
  assign zero1 = ~|din1;
  assign slt   = $signed(din1) < $signed(din2);
  assign ult   = din1 < din2;

  // Decode compare mode into the branch outcome.
  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      (op == BR_BEQ):    cond = (din1 == din2);
      (op == BR_BNE):    cond = (din1 != din2);
      (op == BR_BGEZ):   cond = ~neg1;
      (op == BR_BGTZ):   cond = ~neg1 & ~zero1;
      (op == BR_BLEZ):   cond = neg1 | zero1;
      (op == BR_BLTZ):   cond = neg1;
      (op == BR_BLT):    cond = slt;
      (op == BR_BGE):    cond = ~slt;
      (op == BR_BLTU):   cond = ult;
      (op == BR_BGEU):   cond = ~ult;
      (op == BR_ALWAYS): cond = 1'b1;
      default:           illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// EX branch resolution with registered result record and
// a bimodal history table read by fetch and trained by EX.
module branch_resolve_bht
  import branch_resolve_bht_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int PC_W         = 32,
  parameter int BHT_ENTRIES  = 64,
  parameter int FALLTHRU_OFS = 8
) (
  input logic              clk,
  input logic              rst_n,
  branch_resolve_bht_if.slave s
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  cnt_t bht [BHT_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             cond;
  logic             illegal;
  logic             cap;
  logic             train;
  logic [PC_W-1:0]  fall_pc;
  logic [PC_W-1:0]  redir_nx;

  logic             res_valid;
  logic             res_taken;
  logic             res_mis;
  logic [PC_W-1:0]  res_pc;
  logic             res_ill;

  logic             unused_pc;

  assign rd_idx = s.predPc[IDX_W+1:2];
  assign wr_idx = s.exPc[IDX_W+1:2];

  // Only the index bits of the lookup PC matter.
  assign unused_pc = ^s.predPc;

  // Table read has no bypass from a same-cycle update.
  assign s.predTaken = bht[rd_idx][1];

  branch_cond #(
    .XLEN (XLEN)
  ) u_cond (
    .op      (s.exOp),
    .din1    (s.exDin1),
    .din2    (s.exDin2),
    .cond    (cond),
    .illegal (illegal)
  );

  assign cap      = s.exValid & ~s.stall & ~s.flush;
  assign train    = cap & ~illegal;
  assign fall_pc  = s.exPc + PC_W'(FALLTHRU_OFS);
  assign redir_nx = cond ? s.exTarget : fall_pc;

  // Saturating counter training on legal captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht[i] <= CNT_WNT;
    end else if (train) begin
      bht[wr_idx] <= cnt_next(bht[wr_idx], cond);
    end
  end

  // Resolution record: flush clears, stall holds,
  // capture loads, idle drops the pulse flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_taken <= 1'b0;
      res_mis   <= 1'b0;
      res_pc    <= '0;
      res_ill   <= 1'b0;
    end else if (s.flush) begin
      res_valid <= 1'b0;
      res_mis   <= 1'b0;
      res_ill   <= 1'b0;
    end else if (s.stall) begin
      res_valid <= res_valid;
    end else if (s.exValid) begin
      res_valid <= 1'b1;
      res_ill   <= illegal;
      res_taken <= cond;
      res_mis   <= ~illegal & (cond != s.exPredTaken);
      res_pc    <= redir_nx;
    end else begin
      res_valid <= 1'b0;
      res_mis   <= 1'b0;
      res_ill   <= 1'b0;
    end
  end

  assign s.resValid   = res_valid;
  assign s.resTaken   = res_taken;
  assign s.mispredict = res_mis;
  assign s.redirectPc = res_pc;
  assign s.illegalOp  = res_ill;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht.
// Each task drives one scenario and checks inline.
module tb_branch_resolve_bht;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_resolve_bht_if #(.XLEN(32), .PC_W(32)) bus ();

  branch_resolve_bht #(
    .XLEN(32), .PC_W(32),
    .BHT_ENTRIES(64), .FALLTHRU_OFS(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus.slave)
  );

  logic [3:0]  m_op [15] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd3,
                             4'd4, 4'd4, 4'd5, 4'd5, 4'd7,
                             4'd7, 4'd9, 4'd9, 4'd8, 4'd10};
  logic [31:0] m_d1 [15] = '{32'd3, 32'd0, 32'hFFFFFFFF, 32'd0,
                             32'd1, 32'd0, 32'h80000000,
                             32'h80000000, 32'd0, 32'hFFFFFFFF,
                             32'd5, 32'hFFFFFFFF, 32'd0, 32'd0,
                             32'd0};
  logic [31:0] m_d2 [15] = '{32'd3, 32'd9, 32'd0, 32'd0, 32'd0,
                             32'd0, 32'd0, 32'd0, 32'd0, 32'd1,
                             32'd5, 32'd1, 32'd1, 32'd1, 32'd7};
  logic        m_t  [15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                             1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                             1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.exValid = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic ex(input logic [3:0] op, input logic [31:0] d1,
                    input logic [31:0] d2, input logic [31:0] pc,
                    input logic [31:0] tgt, input logic pt);
    bus.exValid = 1'b1;
    bus.exOp = op;
    bus.exDin1 = d1;
    bus.exDin2 = d2;
    bus.exPc = pc;
    bus.exTarget = tgt;
    bus.exPredTaken = pt;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    ex(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    bus.exValid = 1'b0;
    bus.predPc = 32'h40;
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.predTaken !== 1'b0) begin
      errs++;
      $display("FAIL reset_pred got=%b want=0", bus.predTaken);
    end
    checks++;
    if ({bus.resValid, bus.resTaken, bus.mispredict,
         bus.illegalOp} !== 4'b0 || bus.redirectPc !== 32'h0) begin
      errs++;
      $display("FAIL reset_out got=%b%b%b%b pc=%h want=0",
               bus.resValid, bus.resTaken, bus.mispredict,
               bus.illegalOp, bus.redirectPc);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_beq();
    bus.predPc = 32'h40;
    ex(4'd0, 32'd5, 32'd5, 32'h40, 32'h100, 1'b0);
    tick();
    checks++;
    if ({bus.resValid, bus.resTaken, bus.mispredict,
         bus.illegalOp} !== 4'b1110) begin
      errs++;
      $display("FAIL beq_flags got=%b%b%b%b want=1110",
               bus.resValid, bus.resTaken, bus.mispredict,
               bus.illegalOp);
    end
    checks++;
    if (bus.redirectPc !== 32'h100) begin
      errs++;
      $display("FAIL beq_pc got=%h want=100", bus.redirectPc);
    end
    idle();
    tick();
    checks++;
    if ({bus.resValid, bus.resTaken, bus.mispredict} !== 3'b010 ||
        bus.redirectPc !== 32'h100) begin
      errs++;
      $display("FAIL idle_hold got=%b%b%b pc=%h want=010 pc=100",
               bus.resValid, bus.resTaken, bus.mispredict,
               bus.redirectPc);
    end
  endtask

  task automatic test_signed();
    ex(4'd6, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h400, 1'b0);
    tick();
    checks++;
    if (bus.resTaken !== 1'b1 || bus.redirectPc !== 32'h400) begin
      errs++;
      $display("FAIL blt got=%b pc=%h want=1 pc=400",
               bus.resTaken, bus.redirectPc);
    end
    ex(4'd8, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h400, 1'b0);
    tick();
    checks++;
    if (bus.resTaken !== 1'b0 || bus.redirectPc !== 32'h208 ||
        bus.mispredict !== 1'b0) begin
      errs++;
      $display("FAIL bltu got=%b mis=%b pc=%h want=0 mis=0 pc=208",
               bus.resTaken, bus.mispredict, bus.redirectPc);
    end
    idle();
    tick();
  endtask

  task automatic test_modes();
    logic [31:0] wpc;
    for (int i = 0; i < 15; i++) begin
      ex(m_op[i], m_d1[i], m_d2[i], 32'h300, 32'h600, 1'b1);
      tick();
      wpc = m_t[i] ? 32'h600 : 32'h308;
      checks++;
      if (bus.resTaken !== m_t[i] || bus.redirectPc !== wpc ||
          bus.mispredict !== !m_t[i] || bus.illegalOp !== 1'b0) begin
        errs++;
        $display("FAIL mode%0d op=%0d got=%b pc=%h mis=%b want=%b pc=%h",
                 i, m_op[i], bus.resTaken, bus.redirectPc,
                 bus.mispredict, m_t[i], wpc);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_saturation();
    logic wp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    bus.predPc = 32'h40;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.predTaken !== wp[i]) begin
        errs++;
        $display("FAIL sat_up%0d got=%b want=%b",
                 i, bus.predTaken, wp[i]);
      end
      ex(4'd0, 32'd1, 32'd1, 32'h40, 32'h80, 1'b1);
      tick();
    end
    ex(4'd1, 32'd3, 32'd3, 32'h40, 32'h80, 1'b1);
    tick();
    checks++;
    if (bus.predTaken !== 1'b1) begin
      errs++;
      $display("FAIL sat_dn1 got=%b want=1", bus.predTaken);
    end
    tick();
    checks++;
    if (bus.predTaken !== 1'b0) begin
      errs++;
      $display("FAIL sat_dn2 got=%b want=0", bus.predTaken);
    end
    idle();
    tick();
  endtask

  task automatic test_hazard();
    do_reset();
    bus.predPc = 32'h80;
    ex(4'd0, 32'd1, 32'd1, 32'h80, 32'h180, 1'b0);
    #2;
    checks++;
    if (bus.predTaken !== 1'b0) begin
      errs++;
      $display("FAIL hz_same got=%b want=0", bus.predTaken);
    end
    tick();
    checks++;
    if (bus.predTaken !== 1'b1) begin
      errs++;
      $display("FAIL hz_next got=%b want=1", bus.predTaken);
    end
    idle();
    tick();
  endtask

  task automatic test_stall_flush();
    do_reset();
    bus.predPc = 32'h44;
    ex(4'd1, 32'd1, 32'd2, 32'h44, 32'h300, 1'b0);
    tick();
    bus.stall = 1'b1;
    ex(4'd1, 32'd3, 32'd3, 32'h44, 32'h999, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.resValid, bus.resTaken, bus.mispredict,
           bus.illegalOp} !== 4'b1110 ||
          bus.redirectPc !== 32'h300) begin
        errs++;
        $display("FAIL stall%0d got=%b%b%b%b pc=%h want=1110 pc=300",
                 i, bus.resValid, bus.resTaken, bus.mispredict,
                 bus.illegalOp, bus.redirectPc);
      end
    end
    checks++;
    if (bus.predTaken !== 1'b1) begin
      errs++;
      $display("FAIL stall_bht got=%b want=1", bus.predTaken);
    end
    bus.stall = 1'b0;
    bus.flush = 1'b1;
    tick();
    checks++;
    if (bus.resValid !== 1'b0 || bus.mispredict !== 1'b0 ||
        bus.predTaken !== 1'b1) begin
      errs++;
      $display("FAIL flush got=v%b m%b p%b want=v0 m0 p1",
               bus.resValid, bus.mispredict, bus.predTaken);
    end
    bus.flush = 1'b0;
    ex(4'd1, 32'd1, 32'd2, 32'h44, 32'h300, 1'b0);
    tick();
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    tick();
    checks++;
    if (bus.resValid !== 1'b0) begin
      errs++;
      $display("FAIL flush_stall got=%b want=0", bus.resValid);
    end
    idle();
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    bus.predPc = 32'h44;
    ex(4'd0, 32'd1, 32'd1, 32'h44, 32'h300, 1'b1);
    tick();
    ex(4'd13, 32'd1, 32'd1, 32'h44, 32'h700, 1'b1);
    tick();
    checks++;
    if ({bus.resValid, bus.resTaken, bus.mispredict,
         bus.illegalOp} !== 4'b1001 ||
        bus.redirectPc !== 32'h4C) begin
      errs++;
      $display("FAIL illegal got=%b%b%b%b pc=%h want=1001 pc=4c",
               bus.resValid, bus.resTaken, bus.mispredict,
               bus.illegalOp, bus.redirectPc);
    end
    checks++;
    if (bus.predTaken !== 1'b1) begin
      errs++;
      $display("FAIL illegal_bht got=%b want=1", bus.predTaken);
    end
    idle();
    tick();
    checks++;
    if (bus.illegalOp !== 1'b0 || bus.resValid !== 1'b0) begin
      errs++;
      $display("FAIL illegal_clr got=%b%b want=00",
               bus.illegalOp, bus.resValid);
    end
  endtask

  task automatic test_async_reset();
    bus.predPc = 32'h44;
    ex(4'd10, 32'd0, 32'd0, 32'h44, 32'h500, 1'b0);
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.resValid, bus.resTaken, bus.mispredict,
         bus.illegalOp} !== 4'b0 || bus.redirectPc !== 32'h0) begin
      errs++;
      $display("FAIL arst_out got=%b%b%b%b pc=%h want=0",
               bus.resValid, bus.resTaken, bus.mispredict,
               bus.illegalOp, bus.redirectPc);
    end
    checks++;
    if (bus.predTaken !== 1'b0) begin
      errs++;
      $display("FAIL arst_bht got=%b want=0", bus.predTaken);
    end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_beq();
    test_signed();
    test_modes();
    test_saturation();
    test_hazard();
    test_stall_flush();
    test_illegal();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
